// File: rtl/regfile_scoreboard.sv
// Physical register file with per-entry ready bits for the out-of-order backend.
// Optional same-cycle write->read forwarding is enabled by defining REGFILE_SCOREBOARD_BYPASS_EN.
module regfile_scoreboard #(
  parameter int ENTRY_WIDTH   = 32,
  parameter int N_ENTRIES     = 64,
  parameter int N_READ_PORTS  = 4,
  parameter int N_WRITE_PORTS = 2,
  parameter int N_ALLOC_PORTS = 2,
  parameter int ZERO_REG      = 1,
  localparam int PTR_WIDTH    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_aL,
  input  logic [N_READ_PORTS*PTR_WIDTH-1:0]     rd_addr,
  output logic [N_READ_PORTS*ENTRY_WIDTH-1:0]   rd_data,
  output logic [N_READ_PORTS-1:0]               rd_ready,
  input  logic [N_ALLOC_PORTS-1:0]              alloc_en,
  input  logic [N_ALLOC_PORTS*PTR_WIDTH-1:0]    alloc_addr,
  input  logic [N_WRITE_PORTS-1:0]              wr_en,
  input  logic [N_WRITE_PORTS*PTR_WIDTH-1:0]    wr_addr,
  input  logic [N_WRITE_PORTS*ENTRY_WIDTH-1:0]  wr_data,
  output logic                                  wr_conflict,
  output logic [N_ENTRIES-1:0]                  ready_vec
);

  // Ports carry no handshake: every enabled write/alloc strobe is accepted on the
  // next posedge unconditionally, and reads are purely combinational.

  logic [ENTRY_WIDTH-1:0] mem [N_ENTRIES];
  logic [N_ENTRIES-1:0]   ready_q;
  logic                   conflict_now;

  logic [PTR_WIDTH-1:0]   ra [N_READ_PORTS];
  logic [PTR_WIDTH-1:0]   wa [N_WRITE_PORTS];
  logic [ENTRY_WIDTH-1:0] wd [N_WRITE_PORTS];
  logic [PTR_WIDTH-1:0]   aa [N_ALLOC_PORTS];

  for (genvar k = 0; k < N_READ_PORTS; k++) begin : g_ra
    assign ra[k] = rd_addr[k*PTR_WIDTH +: PTR_WIDTH];
  end
  for (genvar i = 0; i < N_WRITE_PORTS; i++) begin : g_wa
    assign wa[i] = wr_addr[i*PTR_WIDTH +: PTR_WIDTH];
    assign wd[i] = wr_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
  end
  for (genvar j = 0; j < N_ALLOC_PORTS; j++) begin : g_aa
    assign aa[j] = alloc_addr[j*PTR_WIDTH +: PTR_WIDTH];
  end

  function automatic logic in_range(input logic [PTR_WIDTH-1:0] a);
    return int'(a) < N_ENTRIES;
  endfunction

  function automatic logic is_zero_reg(input logic [PTR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Writable means in range and not the hardwired zero entry.
  function automatic logic addr_ok(input logic [PTR_WIDTH-1:0] a);
    return in_range(a) && !is_zero_reg(a);
  endfunction

  always_comb begin
    conflict_now = 1'b0;
    for (int i = 0; i < N_WRITE_PORTS; i++) begin
      for (int j = i + 1; j < N_WRITE_PORTS; j++) begin
        if (wr_en[i] && wr_en[j] && (wa[i] == wa[j]) && addr_ok(wa[i]))
          conflict_now = 1'b1;
      end
    end
  end

  // Allocs are applied after writes so a same-edge alloc leaves the entry not-ready.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int e = 0; e < N_ENTRIES; e++) mem[e] <= '0;
      ready_q     <= '1;
      wr_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < N_WRITE_PORTS; i++) begin
        if (wr_en[i] && addr_ok(wa[i])) begin
          mem[wa[i]]     <= wd[i];
          ready_q[wa[i]] <= 1'b1;
        end
      end
      for (int j = 0; j < N_ALLOC_PORTS; j++) begin
        if (alloc_en[j] && addr_ok(aa[j]))
          ready_q[aa[j]] <= 1'b0;
      end
      if (conflict_now) wr_conflict <= 1'b1;
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    for (int k = 0; k < N_READ_PORTS; k++) begin
      if (is_zero_reg(ra[k])) begin
        rd_data[k*ENTRY_WIDTH +: ENTRY_WIDTH] = '0;
        rd_ready[k]                           = 1'b1;
      end else if (in_range(ra[k])) begin
        rd_data[k*ENTRY_WIDTH +: ENTRY_WIDTH] = mem[ra[k]];
        rd_ready[k]                           = ready_q[ra[k]];
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
        for (int i = 0; i < N_WRITE_PORTS; i++) begin
          if (wr_en[i] && (wa[i] == ra[k])) begin
            rd_data[k*ENTRY_WIDTH +: ENTRY_WIDTH] = wd[i];
            rd_ready[k]                           = 1'b1;
          end
        end
`endif
      end
    end
  end

  assign ready_vec = ready_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized bench for regfile_scoreboard against an array-based reference model.
// Define REGFILE_SCOREBOARD_BYPASS_EN for both files to check the forwarding build.
module tb_regfile_scoreboard;
  localparam int EW = 32;
  localparam int NE = 64;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int NA = 2;
  localparam int PW = 6;

  logic               clk;
  logic               rst_aL;
  logic [NR*PW-1:0]   rd_addr;
  logic [NR*EW-1:0]   rd_data;
  logic [NR-1:0]      rd_ready;
  logic [NA-1:0]      alloc_en;
  logic [NA*PW-1:0]   alloc_addr;
  logic [NW-1:0]      wr_en;
  logic [NW*PW-1:0]   wr_addr;
  logic [NW*EW-1:0]   wr_data;
  logic               wr_conflict;
  logic [NE-1:0]      ready_vec;

  regfile_scoreboard dut (
    .clk(clk), .rst_aL(rst_aL),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_conflict(wr_conflict), .ready_vec(ready_vec)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: entry contents, ready bits, sticky conflict
  logic [EW-1:0] m_data [NE];
  logic          m_ready [NE];
  logic          m_conflict;
  int            n_vec;
  int            n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < NE; e++) begin
      m_data[e]  = '0;
      m_ready[e] = 1'b1;
    end
    m_conflict = 1'b0;
  endtask

  // Expected {ready, data} seen on a read port given the current inputs.
  function automatic logic [EW:0] exp_read(input int a);
    logic [EW:0] r;
    if (a == 0) return {1'b1, {EW{1'b0}}};
    if (a >= NE) return '0;
    r = {m_ready[a], m_data[a]};
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
    for (int i = 0; i < NW; i++)
      if (wr_en[i] && int'(wr_addr[i*PW +: PW]) == a) r = {1'b1, wr_data[i*EW +: EW]};
`endif
    return r;
  endfunction

  function automatic logic [NE-1:0] model_ready_vec();
    logic [NE-1:0] v;
    for (int e = 0; e < NE; e++) v[e] = m_ready[e];
    return v;
  endfunction

  // Apply the edge semantics: writes (highest port last), then allocs override ready.
  task automatic model_edge();
    int seen [$];
    int a;
    for (int i = 0; i < NW; i++) begin
      a = int'(wr_addr[i*PW +: PW]);
      if (wr_en[i] && a != 0 && a < NE) begin
        foreach (seen[s]) if (seen[s] == a) m_conflict = 1'b1;
        seen.push_back(a);
        m_data[a]  = wr_data[i*EW +: EW];
        m_ready[a] = 1'b1;
      end
    end
    for (int j = 0; j < NA; j++) begin
      a = int'(alloc_addr[j*PW +: PW]);
      if (alloc_en[j] && a != 0 && a < NE) m_ready[a] = 1'b0;
    end
  endtask

  // Driver tasks
  task automatic idle();
    wr_en    = '0;
    alloc_en = '0;
  endtask

  task automatic set_read(input int k, input int a);
    rd_addr[k*PW +: PW] = PW'(a);
  endtask

  task automatic set_write(input int i, input int a, input logic [EW-1:0] d);
    wr_en[i]             = 1'b1;
    wr_addr[i*PW +: PW]  = PW'(a);
    wr_data[i*EW +: EW]  = d;
  endtask

  task automatic set_alloc(input int j, input int a);
    alloc_en[j]            = 1'b1;
    alloc_addr[j*PW +: PW] = PW'(a);
  endtask

  // Let inputs settle, then compare every read port and the registered outputs.
  task automatic settle();
    logic [EW:0] e;
    #1;
    for (int k = 0; k < NR; k++) begin
      e = exp_read(int'(rd_addr[k*PW +: PW]));
      check($sformatf("rd_data[%0d]", k), 64'(rd_data[k*EW +: EW]), 64'(e[EW-1:0]));
      check($sformatf("rd_ready[%0d]", k), 64'(rd_ready[k]), 64'(e[EW]));
    end
    check("ready_vec", 64'(ready_vec), 64'(model_ready_vec()));
    check("wr_conflict", 64'(wr_conflict), 64'(m_conflict));
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    edge_step();
  endtask

  function automatic int rand_addr();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NE - 1));
  endfunction

  task automatic random_cycles(input int n, input bit allow_collide);
    for (int c = 0; c < n; c++) begin
      idle();
      for (int k = 0; k < NR; k++) set_read(k, rand_addr());
      for (int i = 0; i < NW; i++)
        if ($urandom_range(0, 1) == 1) set_write(i, rand_addr(), $urandom());
      if (!allow_collide && wr_en == 2'b11 && wr_addr[PW-1:0] == wr_addr[2*PW-1:PW])
        wr_en[0] = 1'b0;
      for (int j = 0; j < NA; j++)
        if ($urandom_range(0, 2) == 0) set_alloc(j, rand_addr());
      step();
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_aL = 1'b0;
    rd_addr = '0; alloc_addr = '0; wr_addr = '0; wr_data = '0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_aL = 1'b1;

    // Reset state visible on all ports
    for (int k = 0; k < NR; k++) set_read(k, k * 17 + 1);
    settle();
    check("reset ready_vec", 64'(ready_vec), {64{1'b1}});
    edge_step();

    // Alloc 5, write 0xDEADBEEF three cycles later
    set_read(0, 5);
    set_alloc(0, 5);
    step();
    idle();
    settle(); check("alloc5 c1 ready", 64'(rd_ready[0]), 64'd0); edge_step();
    settle(); check("alloc5 c2 ready", 64'(rd_ready[0]), 64'd0); edge_step();
    set_write(0, 5, 32'hDEADBEEF);
    step();
    idle();
    settle();
    check("alloc5 c4 data", 64'(rd_data[EW-1:0]), 64'hDEADBEEF);
    check("alloc5 c4 ready", 64'(rd_ready[0]), 64'd1);
    edge_step();

    // Zero register: writes/allocs ignored, duplicate port writes not a conflict
    set_read(1, 0);
    set_write(0, 0, 32'hFFFF);
    set_write(1, 0, 32'h1234);
    set_alloc(1, 0);
    step();
    idle();
    settle();
    check("zero rd_data", 64'(rd_data[2*EW-1:EW]), 64'd0);
    check("zero rd_ready", 64'(rd_ready[1]), 64'd1);
    check("zero no conflict", 64'(wr_conflict), 64'd0);
    edge_step();

    // Bypass behaviour on entry 7
    set_read(2, 7);
    set_write(1, 7, 32'hA5A5);
    settle();
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
    check("bypass same cycle", 64'(rd_data[3*EW-1:2*EW]), 64'hA5A5);
`else
    check("no bypass old value", 64'(rd_data[3*EW-1:2*EW]), 64'd0);
`endif
    edge_step();
    idle();
    settle();
    check("entry7 next cycle", 64'(rd_data[3*EW-1:2*EW]), 64'hA5A5);
    edge_step();

    // Alloc and write on entry 12 together
    set_read(3, 12);
    set_write(0, 12, 32'h3C);
    set_alloc(0, 12);
    step();
    idle();
    settle();
    check("e12 data", 64'(rd_data[4*EW-1:3*EW]), 64'h3C);
    check("e12 ready", 64'(rd_ready[3]), 64'd0);
    edge_step();

    // Collision-free random traffic keeps the sticky flag low
    random_cycles(200, 1'b0);
    check("no conflict yet", 64'(wr_conflict), 64'd0);

    // Collision on entry 9: highest port wins, flag sticks
    set_read(0, 9);
    set_write(0, 9, 32'h11);
    set_write(1, 9, 32'h22);
    step();
    idle();
    settle();
    check("collide data", 64'(rd_data[EW-1:0]), 64'h22);
    check("collide flag", 64'(wr_conflict), 64'd1);
    edge_step();
    repeat (10) step();
    check("collide sticky", 64'(wr_conflict), 64'd1);

    random_cycles(300, 1'b1);

    // Mid-cycle asynchronous reset
    idle();
    for (int k = 0; k < NR; k++) set_read(k, k * 13 + 5);
    #2 rst_aL = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < NR; k++) begin
      check($sformatf("async rst rd_data[%0d]", k), 64'(rd_data[k*EW +: EW]), 64'd0);
      check($sformatf("async rst rd_ready[%0d]", k), 64'(rd_ready[k]), 64'd1);
    end
    check("async rst ready_vec", 64'(ready_vec), {64{1'b1}});
    check("async rst conflict", 64'(wr_conflict), 64'd0);
    @(negedge clk);
    rst_aL = 1'b1;

    random_cycles(200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
